// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the rising-to-rising period and the high time
// of a slow clock-like input in clock_in cycles, with lock and timeout status.
`timescale 1ns/1ps
module clock_period_meter #(
    parameter int WIDTH       = 28,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 2
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             signal_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise, fall;

    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hcnt, hcnt_nxt;
    logic [WIDTH-1:0] hi_lat, hi_lat_nxt;
    logic [WIDTH-1:0] period_nxt, high_nxt;
    logic [3:0]       match_cnt, match_nxt;
    logic             have_prev, have_prev_nxt;
    logic             valid_nxt, locked_nxt, timeout_nxt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Synchronizer chain plus one extra flop for edge detection
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
            s_d    <= s;
        end
    end

    // State register
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: enable dominates, then a rise, then counter saturation
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nxt = MEASURE;
                MEASURE: if (!rise && cnt == CNT_MAX) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath / output next values for the current state and edges
    always_comb begin
        cnt_nxt       = cnt;
        hcnt_nxt      = hcnt;
        hi_lat_nxt    = hi_lat;
        period_nxt    = period;
        high_nxt      = high_time;
        match_nxt     = match_cnt;
        have_prev_nxt = have_prev;
        valid_nxt     = 1'b0;
        timeout_nxt   = timeout;
        // locked trails match_cnt by one cycle
        locked_nxt    = (match_cnt == LOCK_N);
        if (!enable) begin
            cnt_nxt       = '0;
            hcnt_nxt      = '0;
            match_nxt     = '0;
            have_prev_nxt = 1'b0;
            timeout_nxt   = 1'b0;
            locked_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt  = rise ? CNT_ONE : '0;
                    hcnt_nxt = rise ? CNT_ONE : '0;
                end
                MEASURE: begin
                    if (fall) hi_lat_nxt = hcnt;
                    if (rise) begin
                        // a rise at cnt == CNT_MAX still reports, no timeout
                        period_nxt    = cnt;
                        high_nxt      = hi_lat;
                        valid_nxt     = 1'b1;
                        cnt_nxt       = CNT_ONE;
                        hcnt_nxt      = CNT_ONE;
                        timeout_nxt   = 1'b0;
                        have_prev_nxt = 1'b1;
                        if (have_prev && cnt == period)
                            match_nxt = (match_cnt == LOCK_N) ? LOCK_N : match_cnt + 4'd1;
                        else
                            match_nxt = '0;
                    end else if (cnt == CNT_MAX) begin
                        cnt_nxt       = '0;
                        hcnt_nxt      = '0;
                        match_nxt     = '0;
                        have_prev_nxt = 1'b0;
                        timeout_nxt   = 1'b1;
                        locked_nxt    = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (s) hcnt_nxt = hcnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and status registers
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            hcnt      <= '0;
            hi_lat    <= '0;
            period    <= '0;
            high_time <= '0;
            match_cnt <= '0;
            have_prev <= 1'b0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            hcnt      <= hcnt_nxt;
            hi_lat    <= hi_lat_nxt;
            period    <= period_nxt;
            high_time <= high_nxt;
            match_cnt <= match_nxt;
            have_prev <= have_prev_nxt;
            valid     <= valid_nxt;
            locked    <= locked_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule
